blk_bb45a9: RTL

- Converts one linear write request (start address, beat count) plus a beat stream into AXI4 AW/W bursts.
- Splits bursts at MAX_BURST_LEN and at 4 KB boundaries, and generates WLAST.
- Counts B responses and pulses done/err when the request has completed.
- Sits between the output drainer's write-request logic and the AW/W/B register slices of the m_axi adapter.

---
 rtl/blk_bb45a9_pkg.sv | 14 +
 rtl/blk_bb45a9_len_fifo.sv | 39 +++
 rtl/blk_bb45a9.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/blk_bb45a9_pkg.sv
// Shared constants and types for the m_axi write-burst generator.
package blk_bb45a9_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         PAGE_BYTES    = 4096;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/blk_bb45a9_len_fifo.sv
// Burst-length FIFO: holds aw_len (beats-1) of each issued burst until its W beats drain.
module output_drainer_q_fp32_output_mmap_m_axi_len_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;

    // NOTE: the storage array is deliberately left without reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
        end
    end

    assign o_head  = r_mem[r_rd_ptr[PW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

endmodule

// File: rtl/blk_bb45a9.sv
// AXI4 write-burst generator: splits a linear write request into 4 KB-safe AW/W bursts
// and pulses done/err once every B response of the request has returned.
module blk_bb45a9
    import blk_bb45a9_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_BURST_LEN   = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [31:0]             req_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_strb,
    output logic                    aw_valid,
    input  logic                    aw_ready,
    output logic [ADDR_WIDTH-1:0]   aw_addr,
    output logic [7:0]              aw_len,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [DATA_WIDTH-1:0]   w_data,
    output logic [DATA_WIDTH/8-1:0] w_strb,
    output logic                    w_last,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [1:0]              b_resp,
    output logic                    done,
    output logic                    err
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_rem;
    logic [OW-1:0]         r_outst;
    logic [7:0]            r_beat_cnt;
    logic                  r_sticky;
    logic                  r_done;
    logic                  r_err;

    logic                  w_q_full;
    logic                  w_q_empty;
    logic [7:0]            w_q_head;
    logic [12:0]           w_page_beats;
    logic [31:0]           w_beats;
    logic                  w_req_hs;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_last_beat;

    // Beats left before the next 4 KB page; r_addr is always beat-aligned so this is exact.
    assign w_page_beats = (13'(PAGE_BYTES) - {1'b0, r_addr[11:0]}) >> BSH;

    // NOTE: every variable written in always_comb is given a default first, so no path infers a latch.
    always_comb begin
        w_beats = r_rem;
        if (w_beats > 32'(MAX_BURST_LEN)) w_beats = 32'(MAX_BURST_LEN);
        if (w_beats > 32'(w_page_beats))  w_beats = 32'(w_page_beats);
    end

    assign req_ready   = (r_state == IDLE) && !reset;
    assign aw_valid    = (r_state == ISSUE) && (r_outst < OW'(MAX_OUTSTANDING)) && !w_q_full;
    assign aw_addr     = r_addr;
    assign aw_len      = 8'(w_beats - 32'd1);
    assign w_valid     = in_valid && !w_q_empty;
    assign in_ready    = w_ready && !w_q_empty;
    assign w_data      = in_data;
    assign w_strb      = in_strb;
    assign w_last_beat = (r_beat_cnt == w_q_head);
    assign w_last      = w_last_beat && !w_q_empty;
    assign b_ready     = (r_outst != '0);
    assign done        = r_done;
    assign err         = r_err;

    assign w_req_hs = req_valid && req_ready;
    assign w_aw_hs  = aw_valid && aw_ready;
    assign w_w_hs   = w_valid && w_ready;
    assign w_b_hs   = b_valid && b_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req_hs) w_state_nxt = (req_len == 32'd0) ? DONE : ISSUE;
            ISSUE:   if (w_aw_hs && (r_rem == w_beats)) w_state_nxt = DRAIN;
            DRAIN:   if (w_q_empty && (r_outst == '0)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_outst    <= '0;
            r_beat_cnt <= '0;
            r_sticky   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == DONE);
            r_err   <= (r_state == DONE) && r_sticky;

            if (w_req_hs) begin
                r_addr <= req_addr & ~ADDR_WIDTH'(BYTES - 1);
                r_rem  <= req_len;
            end else if (w_aw_hs) begin
                r_addr <= r_addr + (ADDR_WIDTH'(w_beats) << BSH);
                r_rem  <= r_rem - w_beats;
            end

            case ({w_aw_hs, w_b_hs})
                2'b10:   r_outst <= r_outst + OW'(1);
                2'b01:   r_outst <= r_outst - OW'(1);
                default: r_outst <= r_outst;
            endcase

            if (w_w_hs) r_beat_cnt <= w_last_beat ? 8'd0 : r_beat_cnt + 8'd1;

            if (r_state == DONE)                               r_sticky <= 1'b0;
            else if (w_b_hs && (b_resp != AXI_RESP_OKAY))      r_sticky <= 1'b1;
        end
    end

    output_drainer_q_fp32_output_mmap_m_axi_len_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_len_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_aw_hs),
        .i_data  (aw_len),
        .i_pop   (w_w_hs && w_last_beat),
        .o_head  (w_q_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

endmodule
